// File: rtl/subbytes_sched.sv
// Shared AES S-box bank time-multiplexed between the round datapath
// (128-bit state) and key expansion (32-bit SubWord).

module sbox (
  input  logic [7:0] i_in,
  output logic [7:0] o_out
);

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the field inverse and maps 0 to 0
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] s;
    r = 8'h01;
    s = x;
    for (int i = 1; i < 8; i++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b,
                                      input int n);
    logic [7:0] r;
    r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  logic [7:0] w_inv;

  assign w_inv = ginv(i_in);
  assign o_out = w_inv ^ rotl(w_inv, 1) ^ rotl(w_inv, 2)
               ^ rotl(w_inv, 3) ^ rotl(w_inv, 4) ^ 8'h63;

endmodule

module subbytes_sched #(
  parameter int NSBOX = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         data_valid_i,
  output logic         data_ready_o,
  input  logic [127:0] data_i,
  input  logic         key_valid_i,
  output logic         key_ready_o,
  input  logic [31:0]  key_i,
  output logic         data_resp_valid_o,
  output logic [127:0] data_o,
  output logic         key_resp_valid_o,
  output logic [31:0]  key_o,
  output logic         busy_o
);

  if ((NSBOX != 1) && (NSBOX != 2) && (NSBOX != 4)) begin : g_bad_nsbox
    $error("subbytes_sched: NSBOX must be 1, 2 or 4");
  end

  localparam int PD = 16 / NSBOX;
  localparam int PK = 4 / NSBOX;
  localparam int LG = (NSBOX == 4) ? 2 : (NSBOX == 2) ? 1 : 0;
  localparam logic [3:0] LAST_D = 4'(PD - 1);
  localparam logic [3:0] LAST_K = 4'(PK - 1);
  localparam logic SEL_DATA = 1'b0;
  localparam logic SEL_KEY  = 1'b1;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t       r_state;
  state_t       w_next_state;
  logic         r_sel;
  logic         r_last_grant;
  logic [3:0]   r_pass;
  logic [127:0] r_operand;
  logic [127:0] r_result;
  logic [127:0] r_data_o;
  logic [31:0]  r_key_o;
  logic         r_data_rv;
  logic         r_key_rv;

  logic         w_accept;
  logic         w_last;
  logic [3:0]   w_base;
  logic [3:0]   w_lane   [NSBOX];
  logic [7:0]   w_sb_in  [NSBOX];
  logic [7:0]   w_sb_out [NSBOX];
  logic [127:0] w_result_nxt;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: if (w_accept) w_next_state = S_BUSY;
      S_BUSY: if (w_last)   w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Round-robin on a tie: the loser of the last grant wins
  always_comb begin
    data_ready_o = 1'b0;
    key_ready_o  = 1'b0;
    busy_o       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        data_ready_o = data_valid_i
                     & (~key_valid_i | (r_last_grant == SEL_KEY));
        key_ready_o  = key_valid_i
                     & (~data_valid_i | (r_last_grant == SEL_DATA));
      end
      S_BUSY: busy_o = 1'b1;
      default: ;
    endcase
  end

  assign w_accept = data_ready_o | key_ready_o;
  assign w_last   = (r_state == S_BUSY)
                  && (r_pass == ((r_sel == SEL_KEY) ? LAST_K : LAST_D));
  assign w_base   = r_pass << LG;

  for (genvar k = 0; k < NSBOX; k++) begin : g_bank
    assign w_lane[k]  = w_base | 4'(k);
    assign w_sb_in[k] = r_operand[{w_lane[k], 3'b000} +: 8];
    sbox u_sbox (
      .i_in  (w_sb_in[k]),
      .o_out (w_sb_out[k])
    );
  end

  always_comb begin
    w_result_nxt = r_result;
    for (int k = 0; k < NSBOX; k++) begin
      w_result_nxt[{w_lane[k], 3'b000} +: 8] = w_sb_out[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel        <= SEL_DATA;
      r_last_grant <= SEL_KEY;
      r_pass       <= 4'd0;
      r_operand    <= '0;
      r_result     <= '0;
      r_data_o     <= '0;
      r_key_o      <= '0;
      r_data_rv    <= 1'b0;
      r_key_rv     <= 1'b0;
    end else begin
      r_data_rv <= 1'b0;
      r_key_rv  <= 1'b0;
      if (w_accept) begin
        r_operand    <= data_ready_o ? data_i : {96'd0, key_i};
        r_result     <= '0;
        r_sel        <= key_ready_o;
        r_last_grant <= key_ready_o;
        r_pass       <= 4'd0;
      end else if (r_state == S_BUSY) begin
        r_result <= w_result_nxt;
        r_pass   <= r_pass + 4'd1;
        if (w_last) begin
          r_pass <= 4'd0;
          if (r_sel == SEL_KEY) begin
            r_key_rv <= 1'b1;
            r_key_o  <= w_result_nxt[31:0];
          end else begin
            r_data_rv <= 1'b1;
            r_data_o  <= w_result_nxt;
          end
        end
      end
    end
  end

  assign data_resp_valid_o = r_data_rv;
  assign key_resp_valid_o  = r_key_rv;
  assign data_o            = r_data_o;
  assign key_o             = r_key_o;

endmodule
